// File: rtl/rv32i_run_ctrl.sv
// Run controller for rv32i cores: core reset sequencing, cycle/instret counting,
// exit detection by tohost store or EBREAK, and a cycle watchdog.
module rv32i_run_ctrl #(
  parameter int unsigned n            = 32,
  parameter int unsigned depth        = 1024,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned TOHOST_ADDR  = 'h3F0,
  parameter int unsigned CNT_W        = 32,
  localparam int unsigned AW          = $clog2(depth) + 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [n-1:0]     retire_instr,
  input  logic             dmem_we,
  input  logic [AW-1:0]    dmem_addr,
  input  logic [n-1:0]     dmem_wdata,
  output logic             core_reset_n,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [n-2:0]     exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam int unsigned HoldW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast   = HoldW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WdLast     = CNT_W'(MAX_CYCLES - 1);
  localparam logic [AW-1:0]    TohostAddr = AW'(TOHOST_ADDR);
  localparam logic [n-1:0]     Ebreak     = n'(32'h0010_0073);

  typedef enum logic [1:0] {StIdle, StRstHold, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [n-2:0]      exit_code_q, exit_code_d;
  logic              core_reset_n_q, core_reset_n_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic tohost_hit, ebreak_hit, wd_hit, begin_run;

  // A tohost store only signals exit when bit 0 is set; the upper bits carry the code.
  assign tohost_hit = dmem_we && (dmem_addr == TohostAddr) && dmem_wdata[0];
  assign ebreak_hit = retire_valid && (retire_instr == Ebreak);
  assign wd_hit     = (MAX_CYCLES != 0) && (cycle_q == WdLast);
  assign begin_run  = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cycle_d     = cycle_q;
    instret_d   = instret_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRstHold;
      end
      StRstHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StRun: begin
        if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
        if (retire_valid && (instret_q != '1)) instret_d = instret_q + CNT_W'(1);
        if (tohost_hit) begin
          state_d     = StDone;
          exit_code_d = dmem_wdata[n-1:1];
          pass_d      = ~|dmem_wdata[n-1:1];
          timeout_d   = 1'b0;
        end else if (ebreak_hit) begin
          state_d     = StDone;
          exit_code_d = '1;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
        end else if (wd_hit) begin
          state_d     = StDone;
          exit_code_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b1;
        end
      end
      StDone: begin
        if (start) state_d = StRstHold;
      end
      default: state_d = StIdle;
    endcase

    if (begin_run) begin
      hold_d      = '0;
      cycle_d     = '0;
      instret_d   = '0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
      exit_code_d = '0;
    end

    // Status outputs are registered off the next state so they align with the counters.
    core_reset_n_d = (state_d == StRun);
    running_d      = (state_d == StRun);
    done_d         = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      hold_q         <= '0;
      cycle_q        <= '0;
      instret_q      <= '0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      exit_code_q    <= '0;
      core_reset_n_q <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      cycle_q        <= cycle_d;
      instret_q      <= instret_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      exit_code_q    <= exit_code_d;
      core_reset_n_q <= core_reset_n_d;
      running_q      <= running_d;
      done_q         <= done_d;
    end
  end

  assign core_reset_n  = core_reset_n_q;
  assign running       = running_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign exit_code     = exit_code_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Directed bench for rv32i_run_ctrl: a watchdog-enabled instance (MAX_CYCLES=50)
// and a watchdog-disabled instance (MAX_CYCLES=0).
module tb_rv32i_run_ctrl;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          retire_valid = 1'b0;
  logic [N-1:0]  retire_instr = '0;
  logic          dmem_we = 1'b0;
  logic [AW-1:0] dmem_addr = '0;
  logic [N-1:0]  dmem_wdata = '0;

  logic          core_reset_n, running, done, pass, timeout;
  logic [N-2:0]  exit_code;
  logic [31:0]   cycle_count, instret_count;

  logic          b_start = 1'b0;
  logic          b_zero = 1'b0;
  logic [N-1:0]  b_zero_w = '0;
  logic [AW-1:0] b_zero_a = '0;
  logic          b_core_reset_n, b_running, b_done, b_pass, b_timeout;
  logic [N-2:0]  b_exit_code;
  logic [31:0]   b_cycle_count, b_instret_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv32i_run_ctrl #(
    .n(32), .depth(1024), .RESET_CYCLES(4), .MAX_CYCLES(50), .TOHOST_ADDR('h3F0), .CNT_W(32)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .retire_valid(retire_valid), .retire_instr(retire_instr),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_reset_n(core_reset_n), .running(running), .done(done), .pass(pass),
    .timeout(timeout), .exit_code(exit_code),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  rv32i_run_ctrl #(
    .n(32), .depth(1024), .RESET_CYCLES(4), .MAX_CYCLES(0), .TOHOST_ADDR('h3F0), .CNT_W(32)
  ) u_dut_nowd (
    .clk(clk), .reset_n(reset_n), .start(b_start),
    .retire_valid(b_zero), .retire_instr(b_zero_w),
    .dmem_we(b_zero), .dmem_addr(b_zero_a), .dmem_wdata(b_zero_w),
    .core_reset_n(b_core_reset_n), .running(b_running), .done(b_done), .pass(b_pass),
    .timeout(b_timeout), .exit_code(b_exit_code),
    .cycle_count(b_cycle_count), .instret_count(b_instret_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start        = 1'b0;
    retire_valid = 1'b0;
    retire_instr = '0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
  endtask

  // Start pulse plus the four hold cycles; leaves the DUT at the start of RUN cycle 1.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    idle_inputs();
    repeat (2) tick();
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_instret_count", instret_count, 0);

    reset_n = 1'b1;
    tick();
    chk("idle_core_reset_n", core_reset_n, 0);

    // Hold: core_reset_n low for exactly four cycles after the start edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d_core_reset_n", i), core_reset_n, 0);
      chk($sformatf("hold%0d_running", i), running, 0);
      if (i < 3) tick();
    end
    tick();
    chk("run_core_reset_n", core_reset_n, 1);
    chk("run_running", running, 1);
    chk("run_cycle_start", cycle_count, 0);

    // Tohost pass: retires on cycles 1..10, tohost write of 1 on cycle 20.
    for (int k = 1; k <= 20; k++) begin
      retire_valid = (k <= 10);
      retire_instr = 32'h0000_0013;
      if (k == 20) begin
        dmem_we    = 1'b1;
        dmem_addr  = 12'h3F0;
        dmem_wdata = 32'h1;
      end
      tick();
      if (k == 19) begin
        chk("pre_exit_done", done, 0);
        chk("pre_exit_cycle", cycle_count, 19);
      end
    end
    idle_inputs();
    chk("th_pass_done", done, 1);
    chk("th_pass_running", running, 0);
    chk("th_pass_core_reset_n", core_reset_n, 0);
    chk("th_pass_pass", pass, 1);
    chk("th_pass_timeout", timeout, 0);
    chk("th_pass_exit_code", exit_code, 0);
    chk("th_pass_cycle", cycle_count, 20);
    chk("th_pass_instret", instret_count, 10);

    // DONE holds everything even with retire activity.
    retire_valid = 1'b1;
    repeat (3) tick();
    idle_inputs();
    chk("done_hold_instret", instret_count, 10);
    chk("done_hold_cycle", cycle_count, 20);
    chk("done_hold_pass", pass, 1);

    // Restart from DONE: counters/flags cleared, hold replays.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_cycle", cycle_count, 0);
    chk("restart_instret", instret_count, 0);
    chk("restart_done", done, 0);
    chk("restart_pass", pass, 0);
    chk("restart_core_reset_n", core_reset_n, 0);
    repeat (3) tick();
    chk("restart_hold_last", core_reset_n, 0);
    tick();
    chk("restart_run_core_reset_n", core_reset_n, 1);
    chk("restart_run_running", running, 1);

    // Cycle 1: tohost with bit0=0 ignored. Cycle 2: odd data to another address ignored.
    dmem_we = 1'b1; dmem_addr = 12'h3F0; dmem_wdata = 32'h6;
    tick();
    chk("even_tohost_running", running, 1);
    chk("even_tohost_done", done, 0);
    dmem_addr = 12'h3F4; dmem_wdata = 32'h1;
    tick();
    chk("other_addr_done", done, 0);
    // Cycle 3: tohost 7 coincident with EBREAK; tohost wins.
    dmem_addr = 12'h3F0; dmem_wdata = 32'h7;
    retire_valid = 1'b1; retire_instr = 32'h0010_0073;
    tick();
    idle_inputs();
    chk("prio_done", done, 1);
    chk("prio_exit_code", exit_code, 3);
    chk("prio_pass", pass, 0);
    chk("prio_timeout", timeout, 0);
    chk("prio_cycle", cycle_count, 3);
    chk("prio_instret", instret_count, 1);

    // EBREAK exit on RUN cycle 1.
    launch();
    retire_valid = 1'b1; retire_instr = 32'h0010_0073;
    tick();
    idle_inputs();
    chk("ebreak_done", done, 1);
    chk("ebreak_pass", pass, 0);
    chk("ebreak_timeout", timeout, 0);
    chk("ebreak_exit_code", exit_code, 31'h7FFF_FFFF);
    chk("ebreak_instret", instret_count, 1);
    chk("ebreak_cycle", cycle_count, 1);

    // Watchdog at 50 cycles; a start pulse mid-run must be ignored.
    launch();
    chk("wd_start_exit_cleared", exit_code, 0);
    for (int k = 1; k <= 49; k++) begin
      start = (k == 10);
      tick();
    end
    idle_inputs();
    chk("wd_pre_running", running, 1);
    chk("wd_pre_cycle", cycle_count, 49);
    chk("wd_pre_done", done, 0);
    tick();
    chk("wd_done", done, 1);
    chk("wd_timeout", timeout, 1);
    chk("wd_pass", pass, 0);
    chk("wd_exit_code", exit_code, 0);
    chk("wd_cycle", cycle_count, 50);

    // Async reset mid-RUN, asserted away from any clock edge.
    launch();
    retire_valid = 1'b1;
    repeat (5) tick();
    idle_inputs();
    chk("mid_run_running", running, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_core_reset_n", core_reset_n, 0);
    chk("async_running", running, 0);
    chk("async_cycle", cycle_count, 0);
    chk("async_instret", instret_count, 0);
    chk("async_done", done, 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk("post_reset_idle_core_reset_n", core_reset_n, 0);
    chk("post_reset_idle_running", running, 0);

    // Watchdog disabled: still running after 1000 RUN cycles.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (4) tick();
    repeat (1000) tick();
    chk("nowd_running", b_running, 1);
    chk("nowd_done", b_done, 0);
    chk("nowd_timeout", b_timeout, 0);
    chk("nowd_cycle", b_cycle_count, 1000);
    chk("nowd_core_reset_n", b_core_reset_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
